// File: rtl/barrier_array_collider_pkg.sv
// Shared types for the multi-barrier collision engine: side encodings,
// barrier table entry and scan FSM states.
package barrier_pkg;

  localparam int BAR_COORD_W = 10;

  localparam logic [3:0] SIDE_NONE = 4'b0000;
  localparam logic [3:0] SIDE_R    = 4'b0001;
  localparam logic [3:0] SIDE_L    = 4'b0010;
  localparam logic [3:0] SIDE_B    = 4'b0100;
  localparam logic [3:0] SIDE_T    = 4'b1000;

  typedef struct packed {
    logic [BAR_COORD_W-1:0] x;
    logic [BAR_COORD_W-1:0] y;
    logic [BAR_COORD_W-1:0] hl;
    logic [BAR_COORD_W-1:0] hh;
    logic                   valid;
  } barrier_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  typedef logic signed [BAR_COORD_W+1:0] scoord_t;

  // Two guard bits keep edge arithmetic exact: no wrap below 0 or above max.
  function automatic scoord_t ext(input logic [BAR_COORD_W-1:0] v);
    return scoord_t'({2'b00, v});
  endfunction

endpackage

// File: rtl/barrier_array_collider_hit_check.sv
// Combinational test of one object against one barrier; returns the first
// matching side in priority order R, L, B, T, or SIDE_NONE.
module barrier_hit_check
  import barrier_pkg::*;
(
  input  logic [BAR_COORD_W-1:0] obj_x,
  input  logic [BAR_COORD_W-1:0] obj_y,
  input  logic [BAR_COORD_W-1:0] obj_size,
  input  barrier_t               bar,
  output logic [3:0]             side
);

  scoord_t o_l, o_r, o_t, o_b;
  scoord_t b_l, b_r, b_t, b_b;
  logic    x_span, y_span;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_l = ext(obj_x) - ext(obj_size);
    o_r = ext(obj_x) + ext(obj_size);
    o_t = ext(obj_y) - ext(obj_size);
    o_b = ext(obj_y) + ext(obj_size);
    b_l = ext(bar.x) - ext(bar.hl);
    b_r = ext(bar.x) + ext(bar.hl);
    b_t = ext(bar.y) - ext(bar.hh);
    b_b = ext(bar.y) + ext(bar.hh);

    x_span = (o_r >= b_l) && (o_l <= b_r);
    y_span = (o_b >= b_t) && (o_t <= b_b);

    side = SIDE_NONE;
    if (bar.valid) begin
      // An object edge lying inside the barrier's extent, with overlap on the other axis.
      if (y_span && (o_r >= b_l) && (o_r <= b_r))      side = SIDE_R;
      else if (y_span && (o_l >= b_l) && (o_l <= b_r)) side = SIDE_L;
      else if (x_span && (o_b >= b_t) && (o_b <= b_b)) side = SIDE_B;
      else if (x_span && (o_t >= b_t) && (o_t <= b_b)) side = SIDE_T;
    end
  end

endmodule

// File: rtl/barrier_array_collider.sv
// Multi-barrier collision engine: scans a writable barrier table once per
// frame, all objects in parallel. Optional feature macro: BARRIER_DESTRUCT_EN.
module barrier_array_collider
  import barrier_pkg::*;
#(
  parameter int N_BARRIERS = 8,
  parameter int N_OBJ      = 4,
  parameter int COORD_W    = 10,
  parameter int BAR_HP     = 3
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                start,
  input  logic [N_OBJ*COORD_W-1:0]            obj_x,
  input  logic [N_OBJ*COORD_W-1:0]            obj_y,
  input  logic [N_OBJ*COORD_W-1:0]            obj_size,
  input  logic [N_OBJ-1:0]                    obj_is_bullet,
  input  logic                                bar_we,
  input  logic [$clog2(N_BARRIERS)-1:0]       bar_idx,
  input  logic [COORD_W-1:0]                  bar_x,
  input  logic [COORD_W-1:0]                  bar_y,
  input  logic [COORD_W-1:0]                  bar_hl,
  input  logic [COORD_W-1:0]                  bar_hh,
  input  logic                                bar_valid,
  output logic [N_OBJ*4-1:0]                  obj_side,
  output logic [N_OBJ-1:0]                    obj_hit,
  output logic [N_OBJ*$clog2(N_BARRIERS)-1:0] obj_hit_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int IDX_W = $clog2(N_BARRIERS);

  if (COORD_W != BAR_COORD_W) begin : g_width_check
    $error("COORD_W must equal barrier_pkg::BAR_COORD_W");
  end
  if (BAR_HP < 1) begin : g_hp_check
    $error("BAR_HP must be at least 1");
  end

  scan_state_e state, state_next;
  logic [IDX_W-1:0] k;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LATCH;
      LATCH:   state_next = SCAN;
      SCAN:    if (k == IDX_W'(N_BARRIERS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Barrier table
  logic [COORD_W-1:0]    bx_q [N_BARRIERS];
  logic [COORD_W-1:0]    by_q [N_BARRIERS];
  logic [COORD_W-1:0]    bhl_q[N_BARRIERS];
  logic [COORD_W-1:0]    bhh_q[N_BARRIERS];
  logic [N_BARRIERS-1:0] valid_q;

  // NOTE: geometry storage is left unreset; only the valid bits need a known state after reset.
  always_ff @(posedge Clk) begin
    if (bar_we) begin
      bx_q[bar_idx]  <= bar_x;
      by_q[bar_idx]  <= bar_y;
      bhl_q[bar_idx] <= bar_hl;
      bhh_q[bar_idx] <= bar_hh;
    end
  end

  barrier_t cur_bar;
  always_comb begin
    cur_bar.x     = bx_q[k];
    cur_bar.y     = by_q[k];
    cur_bar.hl    = bhl_q[k];
    cur_bar.hh    = bhh_q[k];
    cur_bar.valid = valid_q[k] && (state == SCAN);
  end

  // Object snapshot taken in LATCH so mid-frame input motion is ignored.
  logic [N_OBJ*COORD_W-1:0] snap_x, snap_y, snap_size;
  logic [N_OBJ-1:0]         snap_bullet;

  always_ff @(posedge Clk) begin
    if (state == LATCH) begin
      snap_x      <= obj_x;
      snap_y      <= obj_y;
      snap_size   <= obj_size;
      snap_bullet <= obj_is_bullet;
    end
  end

  logic [3:0] side_now [N_OBJ];

  for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
    barrier_hit_check u_hit_check (
      .obj_x    (snap_x[i*COORD_W +: COORD_W]),
      .obj_y    (snap_y[i*COORD_W +: COORD_W]),
      .obj_size (snap_size[i*COORD_W +: COORD_W]),
      .bar      (cur_bar),
      .side     (side_now[i])
    );
  end

`ifdef BARRIER_DESTRUCT_EN
  localparam int HP_W = $clog2(BAR_HP + 1);

  logic [HP_W-1:0] hp_q [N_BARRIERS];
  int              bullet_cnt;
  int              hp_cur;

  always_comb begin
    bullet_cnt = 0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (snap_bullet[i] && (side_now[i] != SIDE_NONE)) bullet_cnt = bullet_cnt + 1;
    end
    hp_cur = int'(hp_q[k]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      for (int j = 0; j < N_BARRIERS; j++) hp_q[j] <= '0;
    end else begin
      if (cur_bar.valid && (bullet_cnt != 0)) begin
        if (bullet_cnt >= hp_cur) begin
          hp_q[k]    <= '0;
          valid_q[k] <= 1'b0;
        end else begin
          hp_q[k] <= HP_W'(hp_cur - bullet_cnt);
        end
      end
      // A table write lands last so it overrides a same-cycle decrement.
      if (bar_we) begin
        valid_q[bar_idx] <= bar_valid;
        if (bar_valid) hp_q[bar_idx] <= HP_W'(BAR_HP);
      end
    end
  end
`else
  logic unused_bullet;
  assign unused_bullet = ^snap_bullet;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       valid_q <= '0;
    else if (bar_we) valid_q[bar_idx] <= bar_valid;
  end
`endif

  // Accumulators and registered outputs
  logic [N_OBJ*4-1:0]     acc_side;
  logic [N_OBJ-1:0]       acc_hit;
  logic [N_OBJ*IDX_W-1:0] acc_idx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k           <= '0;
      acc_side    <= '0;
      acc_hit     <= '0;
      acc_idx     <= '0;
      obj_side    <= '0;
      obj_hit     <= '0;
      obj_hit_idx <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LATCH: begin
          k        <= '0;
          acc_side <= '0;
          acc_hit  <= '0;
          acc_idx  <= '0;
        end
        SCAN: begin
          k <= k + 1'b1;
          for (int i = 0; i < N_OBJ; i++) begin
            if (side_now[i] != SIDE_NONE) begin
              acc_side[i*4 +: 4] <= acc_side[i*4 +: 4] | side_now[i];
              if (!acc_hit[i]) begin
                acc_hit[i]               <= 1'b1;
                acc_idx[i*IDX_W +: IDX_W] <= k;
              end
            end
          end
        end
        DONE: begin
          obj_side    <= acc_side;
          obj_hit     <= acc_hit;
          obj_hit_idx <= acc_idx;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
